// File: rtl/sync_data_memory.sv
`default_nettype none
// ============================================================================
// Module      : sync_data_memory
// Description : Single-port synchronous data memory for the datapath.
//               Valid/ready request port, configurable read latency,
//               byte-lane write enables and an optional hardware clear
//               sequence that zeroes every word after reset.
// Ports       : clk             - clock, rising edge
//               rst_n           - asynchronous active-low reset
//               req_valid       - request present
//               req_ready       - request accepted this cycle when high
//               req_write       - 1 = write, 0 = read
//               req_address     - word address
//               req_write_data  - write data
//               req_byte_enable - per-byte write enables (ignored on reads)
//               resp_valid      - read data valid this cycle
//               resp_read_data  - read data, held while resp_valid is low
//               busy            - clear sequence in progress
// Revision    : 1.0 - initial release
// ============================================================================
module sync_data_memory #(
    parameter int DATA_WIDTH     = 16,
    parameter int ADDR_WIDTH     = 10,
    parameter int READ_LATENCY   = 1,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic                      req_write,
    input  logic [ADDR_WIDTH-1:0]     req_address,
    input  logic [DATA_WIDTH-1:0]     req_write_data,
    input  logic [DATA_WIDTH/8-1:0]   req_byte_enable,
    output logic                      resp_valid,
    output logic [DATA_WIDTH-1:0]     resp_read_data,
    output logic                      busy
);

    localparam int c_DEPTH = 2 ** ADDR_WIDTH;
    localparam int c_LANES = DATA_WIDTH / 8;

    localparam logic [ADDR_WIDTH-1:0] c_LAST_ADDR = {ADDR_WIDTH{1'b1}};

    localparam logic [0:0] c_ST_CLEAR = 1'b0;
    localparam logic [0:0] c_ST_READY = 1'b1;
    localparam logic [0:0] c_ST_RESET = (CLEAR_ON_RESET != 0) ? c_ST_CLEAR : c_ST_READY;

    logic [0:0]             r_state;
    logic [0:0]             w_state_next;
    logic [ADDR_WIDTH-1:0]  r_clr_cnt;
    logic                   w_clr_we;
    logic                   w_wr;
    logic                   w_rd;

    logic [DATA_WIDTH-1:0]  r_mem [c_DEPTH];

    // Sample stage: captures the array on the acceptance edge.
    logic                   r_smp_valid;
    logic [DATA_WIDTH-1:0]  r_smp_data;

    // Response pipeline, READ_LATENCY stages deep; the last stage drives the port.
    logic                   r_pipe_valid [READ_LATENCY];
    logic [DATA_WIDTH-1:0]  r_pipe_data  [READ_LATENCY];

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= c_ST_RESET;
            r_clr_cnt <= '0;
        end else begin
            r_state <= w_state_next;
            // Counter parks on the last address instead of wrapping.
            if (r_state == c_ST_CLEAR && r_clr_cnt != c_LAST_ADDR) begin
                r_clr_cnt <= r_clr_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        busy         = 1'b0;
        req_ready    = 1'b0;
        w_clr_we     = 1'b0;
        if (r_state == c_ST_CLEAR) begin
            busy     = 1'b1;
            w_clr_we = 1'b1;
            if (r_clr_cnt == c_LAST_ADDR) begin
                w_state_next = c_ST_READY;
            end
        end else begin
            req_ready = 1'b1;
        end
    end

    assign w_wr = req_valid && req_ready &&  req_write;
    assign w_rd = req_valid && req_ready && !req_write;

    // ------------------------------------------------------------------
    // Storage: not reset; cleared word-by-word by the FSM when enabled.
    // Clear and request writes are mutually exclusive by FSM state.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_clr_we) begin
            r_mem[r_clr_cnt] <= '0;
        end else if (w_wr) begin
            for (int i = 0; i < c_LANES; i++) begin
                if (req_byte_enable[i]) begin
                    r_mem[req_address][8*i +: 8] <= req_write_data[8*i +: 8];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Read path. Data registers only load when a valid entry moves in, so
    // the output stage naturally holds the last valid read data.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_smp_valid <= 1'b0;
            r_smp_data  <= '0;
        end else begin
            r_smp_valid <= w_rd;
            if (w_rd) begin
                r_smp_data <= r_mem[req_address];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < READ_LATENCY; k++) begin
                r_pipe_valid[k] <= 1'b0;
                r_pipe_data[k]  <= '0;
            end
        end else begin
            r_pipe_valid[0] <= r_smp_valid;
            if (r_smp_valid) begin
                r_pipe_data[0] <= r_smp_data;
            end
            for (int k = 1; k < READ_LATENCY; k++) begin
                r_pipe_valid[k] <= r_pipe_valid[k-1];
                if (r_pipe_valid[k-1]) begin
                    r_pipe_data[k] <= r_pipe_data[k-1];
                end
            end
        end
    end

    assign resp_valid     = r_pipe_valid[READ_LATENCY-1];
    assign resp_read_data = r_pipe_data[READ_LATENCY-1];

endmodule
`default_nettype wire

// File: tb/tb_sync_data_memory.sv
`default_nettype none
// ============================================================================
// Module      : tb_sync_data_memory
// Description : Directed self-checking bench for sync_data_memory. Instance A
//               uses clear-on-reset with READ_LATENCY=2; instance B has no
//               clear and READ_LATENCY=3. Request inputs are shared; each
//               instance has its own reset so only one is active at a time.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sync_data_memory;

    logic        clk = 1'b0;
    logic        rst_a;
    logic        rst_b;
    logic        req_valid;
    logic        req_write;
    logic [9:0]  req_address;
    logic [15:0] req_write_data;
    logic [1:0]  req_byte_enable;

    logic        ready_a, resp_valid_a, busy_a;
    logic [15:0] resp_data_a;
    logic        ready_b, resp_valid_b, busy_b;
    logic [15:0] resp_data_b;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    sync_data_memory #(
        .DATA_WIDTH(16), .ADDR_WIDTH(10), .READ_LATENCY(2), .CLEAR_ON_RESET(1)
    ) u_dut_a (
        .clk(clk), .rst_n(rst_a),
        .req_valid(req_valid), .req_ready(ready_a), .req_write(req_write),
        .req_address(req_address), .req_write_data(req_write_data),
        .req_byte_enable(req_byte_enable),
        .resp_valid(resp_valid_a), .resp_read_data(resp_data_a), .busy(busy_a)
    );

    sync_data_memory #(
        .DATA_WIDTH(16), .ADDR_WIDTH(10), .READ_LATENCY(3), .CLEAR_ON_RESET(0)
    ) u_dut_b (
        .clk(clk), .rst_n(rst_b),
        .req_valid(req_valid), .req_ready(ready_b), .req_write(req_write),
        .req_address(req_address), .req_write_data(req_write_data),
        .req_byte_enable(req_byte_enable),
        .resp_valid(resp_valid_b), .resp_read_data(resp_data_b), .busy(busy_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic get_valid(input bit sel);
        return sel ? resp_valid_b : resp_valid_a;
    endfunction

    function automatic logic [15:0] get_data(input bit sel);
        return sel ? resp_data_b : resp_data_a;
    endfunction

    task automatic wr(input logic [9:0] addr, input logic [15:0] data, input logic [1:0] be);
        req_valid = 1'b1; req_write = 1'b1;
        req_address = addr; req_write_data = data; req_byte_enable = be;
        tick();
        req_valid = 1'b0;
    endtask

    // Read accepted at the next edge T; response must appear only after
    // edge T+lat, last one cycle, and its data must then hold.
    task automatic read_chk(input bit sel, input logic [9:0] addr, input logic [15:0] exp,
                            input int lat, input string tag);
        req_valid = 1'b1; req_write = 1'b0; req_address = addr;
        tick();
        req_valid = 1'b0;
        for (int k = 1; k < lat; k++) begin
            tick();
            check({tag, "_early_valid"}, 32'(get_valid(sel)), 32'd0);
        end
        tick();
        check({tag, "_valid"}, 32'(get_valid(sel)), 32'd1);
        check({tag, "_data"},  32'(get_data(sel)),  32'(exp));
        tick();
        check({tag, "_one_cycle"}, 32'(get_valid(sel)), 32'd0);
        check({tag, "_hold"},      32'(get_data(sel)),  32'(exp));
    endtask

    // Called right after releasing rst_a, before the first post-reset edge.
    task automatic measure_clear(output int busy_cyc, output int ready_cyc, output int valid_cyc);
        busy_cyc = 0; ready_cyc = 0; valid_cyc = 0;
        for (int i = 0; i < 1024; i++) begin
            if (busy_a)       busy_cyc++;
            if (ready_a)      ready_cyc++;
            if (resp_valid_a) valid_cyc++;
            tick();
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int bc, rc, vc, vc_pre;
        rst_a = 1'b0; rst_b = 1'b0;
        req_valid = 1'b0; req_write = 1'b0; req_address = '0;
        req_write_data = '0; req_byte_enable = '0;
        repeat (3) tick();

        // Reset values
        check("rst_a_ready", 32'(ready_a),      32'd0);
        check("rst_a_busy",  32'(busy_a),       32'd1);
        check("rst_a_valid", 32'(resp_valid_a), 32'd0);
        check("rst_a_data",  32'(resp_data_a),  32'h0);
        check("rst_b_ready", 32'(ready_b),      32'd1);
        check("rst_b_busy",  32'(busy_b),       32'd0);
        check("rst_b_valid", 32'(resp_valid_b), 32'd0);
        check("rst_b_data",  32'(resp_data_b),  32'h0);

        // Clear sequence with a write request held pending on word 0
        req_valid = 1'b1; req_write = 1'b1; req_address = 10'd0;
        req_write_data = 16'hFFFF; req_byte_enable = 2'b11;
        rst_a = 1'b1;
        measure_clear(bc, rc, vc);
        req_valid = 1'b0;
        check("clear_busy_cycles", 32'(bc), 32'd1024);
        check("clear_ready_cycles", 32'(rc), 32'd0);
        check("clear_end_busy",  32'(busy_a),  32'd0);
        check("clear_end_ready", 32'(ready_a), 32'd1);
        read_chk(1'b0, 10'd0,    16'h0000, 2, "clr_rd0");
        read_chk(1'b0, 10'd500,  16'h0000, 2, "clr_rd500");
        read_chk(1'b0, 10'd1023, 16'h0000, 2, "clr_rd1023");

        // Byte lanes
        wr(10'd5, 16'h1234, 2'b11);
        wr(10'd5, 16'hABCD, 2'b01);
        read_chk(1'b0, 10'd5, 16'h12CD, 2, "lane_lo");
        wr(10'd5, 16'hFFFF, 2'b00);
        read_chk(1'b0, 10'd5, 16'h12CD, 2, "lane_none");
        wr(10'd6, 16'h5678, 2'b11);
        wr(10'd6, 16'h9900, 2'b10);
        read_chk(1'b0, 10'd6, 16'h9978, 2, "lane_hi");

        // Streaming reads, latency 2
        for (int i = 0; i < 10; i++) wr(10'(500 + i), 16'(i + 1), 2'b11);
        for (int j = 0; j < 14; j++) begin
            req_valid = (j < 10); req_write = 1'b0; req_address = 10'(500 + j);
            tick();
            check("stream_valid", 32'(resp_valid_a), (j >= 2 && j <= 11) ? 32'd1 : 32'd0);
            if (j >= 2 && j <= 11) check("stream_data", 32'(resp_data_a), 32'(j - 1));
        end
        req_valid = 1'b0;

        // Reset with reads in flight
        for (int j = 0; j < 3; j++) begin
            req_valid = 1'b1; req_write = 1'b0; req_address = 10'(500 + j);
            tick();
        end
        req_valid = 1'b0;
        check("mid_pre_valid", 32'(resp_valid_a), 32'd1);
        check("mid_pre_data",  32'(resp_data_a),  32'd1);
        rst_a = 1'b0;
        #1;
        check("mid_rst_valid", 32'(resp_valid_a), 32'd0);
        check("mid_rst_busy",  32'(busy_a),       32'd1);
        check("mid_rst_ready", 32'(ready_a),      32'd0);
        tick();
        tick();
        rst_a = 1'b1;
        vc_pre = 0;
        for (int i = 0; i < 300; i++) begin
            if (resp_valid_a) vc_pre++;
            tick();
        end
        check("mid_clr300_busy", 32'(busy_a), 32'd1);
        rst_a = 1'b0;
        #1;
        check("mid_rst2_busy", 32'(busy_a), 32'd1);
        rst_a = 1'b1;
        measure_clear(bc, rc, vc);
        check("mid_lost_reads", 32'(vc + vc_pre), 32'd0);
        check("mid_clear_busy_cycles", 32'(bc), 32'd1024);
        check("mid_clear_ready_cycles", 32'(rc), 32'd0);
        check("mid_clear_end_ready", 32'(ready_a), 32'd1);
        read_chk(1'b0, 10'd500, 16'h0000, 2, "mid_recleared");

        // Instance B: no clear, latency 3
        rst_a = 1'b0;
        tick();
        rst_b = 1'b1;
        tick();
        check("noclr_ready", 32'(ready_b), 32'd1);
        check("noclr_busy",  32'(busy_b),  32'd0);
        wr(10'd7, 16'hBEEF, 2'b11);
        read_chk(1'b1, 10'd7, 16'hBEEF, 3, "lat3");
        wr(10'd20, 16'h5A5A, 2'b11);
        read_chk(1'b1, 10'd20, 16'h5A5A, 3, "noclr_wr_rd");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sync_data_memory.md
# sync_data_memory

Parametrised, single-port, synchronous data memory for the datapath: a valid/ready request port, configurable read latency, byte-lane write enables and a hardware clear sequence after reset. It supersedes the fixed 1024x16 combinational-read memory. It sits between the datapath's load/store unit and its register file write-back.

## Interface
Parameters:
- DATA_WIDTH, 16, word width in bits; must be a multiple of 8
- ADDR_WIDTH, 10, address width; depth is 2**ADDR_WIDTH words
- READ_LATENCY, 1, cycles from read acceptance to response; legal range 1..4
- CLEAR_ON_RESET, 1, when 1 every word is zeroed after reset before requests are accepted

Ports:
- clk  input  1  clock; all state updates on the rising edge
- rst_n  input  1  reset; asynchronous, active-low
- req_valid  input  1  request present
- req_ready  output  1  block accepts a request this cycle
- req_write  input  1  1 = write, 0 = read
- req_address  input  ADDR_WIDTH  word address
- req_write_data  input  DATA_WIDTH  write data
- req_byte_enable  input  DATA_WIDTH/8  lane i covers bits [8i+7:8i]; ignored on reads
- resp_valid  output  1  read data valid this cycle
- resp_read_data  output  DATA_WIDTH  read data
- busy  output  1  clear sequence in progress

## Operation
- Accept: a request is accepted on a rising edge where req_valid && req_ready.
- FSM states: CLEAR, READY.
  - rst_n low: go to CLEAR if CLEAR_ON_RESET=1, otherwise READY.
  - CLEAR: a counter steps 0 to DEPTH-1 and writes all-zero to one word per cycle.
    - busy=1, req_ready=0 throughout.
    - After writing DEPTH-1, go to READY. The counter does not wrap.
  - READY: req_ready=1 every cycle. There is no back-pressure from the response side.
- Write: on acceptance, each lane with its enable set takes its req_write_data bits. Lanes with the enable clear keep their value. No response is produced.
  - A write with byte enables all zero is accepted and has no effect.
- Read: fully pipelined, one read per cycle.
  - The array is sampled at the acceptance edge.
  - A READ_LATENCY-deep shift register carries the valid flag and data.
  - A read accepted one cycle after a write to the same address returns the new data.
- resp_read_data holds its last valid value while resp_valid=0.
- Array contents are not reset. With CLEAR_ON_RESET=0, contents after reset are undefined until written. No contents are preloaded.
- Reset mid-operation (any state, any time):
  - flush the response pipeline: resp_valid=0, in-flight reads are lost;
  - restart CLEAR from word 0 if enabled;
  - words already written keep their values unless re-cleared.

## Timing
- Reset values:
  - req_ready = 0 if CLEAR_ON_RESET=1, else 1
  - busy = CLEAR_ON_RESET
  - resp_valid = 0
  - resp_read_data = 0
  - clear counter = 0
- Clear duration: exactly DEPTH cycles after rst_n deasserts. On the edge that writes word DEPTH-1, busy falls and req_ready rises.
  - Default parameters: req_ready first high in cycle 1024 counting the first post-reset edge as cycle 0.
- Read accepted at edge T: resp_valid=1 and data valid after edge T+READ_LATENCY, for exactly one cycle per read.
- Back-to-back reads at edges T, T+1, T+2 give responses after edges T+L, T+L+1, T+L+2, in order.
- Write accepted at edge T: visible to a read accepted at edge T+1.

## Test plan
- Clear: default parameters, release rst_n, hold req_valid=1 -> busy high for 1024 cycles, no acceptance during clear; then reads of addresses 0, 500, 1023 each return 0x0000.
- Latency: READ_LATENCY=3, write 0xBEEF to address 7, then read address 7 on the next cycle -> resp_valid exactly 3 cycles after the read is accepted, data 0xBEEF.
- Byte lanes: write 0x1234 to address 5 (enable 2'b11), then write 0xABCD with enable 2'b01 -> read returns 0x12CD. A following write with enable 2'b00 leaves 0x12CD.
- Streaming reads: after writes 1..10 to addresses 500..509, issue 10 consecutive reads of 500..509 with READ_LATENCY=2 -> 10 consecutive resp_valid cycles returning 1..10 in order, no gaps.
- Reset mid-operation: assert rst_n low with two reads in flight and again at clear counter 300 -> resp_valid drops immediately and never reports the lost reads; clear restarts at 0 and lasts a full 1024 cycles.
- CLEAR_ON_RESET=0: release rst_n -> req_ready=1 and busy=0 at the first edge; a write then a read of the same address returns the written value one cycle later.
